// File: rtl/prio_arbiter_fsm_amisha.sv
// Four-requester arbiter with fixed-priority or round-robin selection, grant ownership
// and a hold-time limit that forces a direct handover when others are waiting.
module prio_arbiter_fsm_amisha #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk_amisha,
  input  logic       rst_n_amisha,
  input  logic [4:1] req_amisha,
  input  logic       rr_mode_amisha,
  output logic [4:1] grant_amisha,
  output logic [2:0] gid_amisha,
  output logic       busy_amisha,
  output logic       expire_amisha
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  // Requester indices are kept 0-based internally: 0 is requester 1, 3 is requester 4.
  state_e     state_q;
  logic [1:0] owner_q;
  logic [1:0] last_q;
  logic [7:0] cnt_q;
  logic [3:0] grant_q;
  logic [2:0] gid_q;
  logic       expire_q;

  logic [3:0] req_v;
  logic [3:0] owner_mask;
  logic       req_owner;
  logic       others_pending;
  logic [1:0] win_any;
  logic [1:0] win_other;

  // RR search walks downward from last-1, wrapping, and visits last itself at the end.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic rr,
                                      input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] idx;
    w = 2'd0;
    if (!rr) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) w = 2'(i);
      end
    end else begin
      for (int k = 4; k >= 1; k--) begin
        idx = last - 2'(k);
        if (r[idx]) w = idx;
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  always_comb begin
    req_v          = req_amisha;
    owner_mask     = onehot(owner_q);
    req_owner      = |(req_v & owner_mask);
    others_pending = |(req_v & ~owner_mask);
    win_any        = pick(req_v, rr_mode_amisha, last_q);
    win_other      = pick(req_v & ~owner_mask, rr_mode_amisha, last_q);
  end

  always_ff @(posedge clk_amisha) begin
    if (!rst_n_amisha) begin
      state_q  <= IDLE;
      owner_q  <= 2'd0;
      last_q   <= 2'd0;
      cnt_q    <= 8'd0;
      grant_q  <= 4'b0000;
      gid_q    <= 3'b000;
      expire_q <= 1'b0;
    end else begin
      expire_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_v) begin
            state_q <= OWN;
            owner_q <= win_any;
            last_q  <= win_any;
            cnt_q   <= 8'd1;
            grant_q <= onehot(win_any);
            gid_q   <= {1'b0, win_any} + 3'd1;
          end else begin
            grant_q <= 4'b0000;
            gid_q   <= 3'b000;
          end
        end
        OWN: begin
          // Release outranks expiry, so a simultaneous drop never pulses expire.
          if (!req_owner) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            gid_q   <= 3'b000;
          end else if (cnt_q == HOLD_MAX_C && others_pending) begin
            owner_q  <= win_other;
            last_q   <= win_other;
            cnt_q    <= 8'd1;
            grant_q  <= onehot(win_other);
            gid_q    <= {1'b0, win_other} + 3'd1;
            expire_q <= 1'b1;
          end else if (cnt_q != HOLD_MAX_C) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 4'b0000;
          gid_q   <= 3'b000;
        end
      endcase
    end
  end

  assign grant_amisha  = grant_q;
  assign gid_amisha    = gid_q;
  assign busy_amisha   = (state_q == OWN);
  assign expire_amisha = expire_q;

endmodule

// File: tb/tb_prio_arbiter_fsm_amisha.sv
// Directed bench for prio_arbiter_fsm_amisha with HOLD_MAX=4; expected outputs are queued
// as each cycle of stimulus is driven and checked one edge later.
module tb_prio_arbiter_fsm_amisha;

  logic       clk;
  logic       rst_n;
  logic [4:1] req;
  logic       rr;
  logic [4:1] grant;
  logic [2:0] gid;
  logic       busy;
  logic       expire;

  int n_cmp = 0;
  int n_mis = 0;

  // Packed expectation: {grant[3:0], gid[2:0], busy, expire}
  logic [8:0] exp_q[$];

  prio_arbiter_fsm_amisha #(.HOLD_MAX(4)) dut (
    .clk_amisha    (clk),
    .rst_n_amisha  (rst_n),
    .req_amisha    (req),
    .rr_mode_amisha(rr),
    .grant_amisha  (grant),
    .gid_amisha    (gid),
    .busy_amisha   (busy),
    .expire_amisha (expire)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] eg,
                     input logic [2:0] eid, input logic eb, input logic ee);
    logic [8:0] e;
    req = r;
    exp_q.push_back({eg, eid, eb, ee});
    @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_mis++;
      $error("FAIL %s.queue: got empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".grant"},  grant,          e[8:5]);
      chk({tag, ".gid"},    {1'b0, gid},    {1'b0, e[4:2]});
      chk({tag, ".busy"},   {3'b000, busy},   {3'b000, e[1]});
      chk({tag, ".expire"}, {3'b000, expire}, {3'b000, e[0]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    rr    = 1'b0;
    @(negedge clk);

    // Reset held two cycles with all requests up, then release
    cyc("rst0", 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("rst1", 4'b1111, 4'b0000, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("rst_rel", 4'b1111, 4'b1000, 3'b100, 1'b1, 1'b0);
    cyc("rst_drop", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Fixed priority and release with one idle cycle
    cyc("fix_g3", 4'b0110, 4'b0100, 3'b011, 1'b1, 1'b0);
    cyc("fix_rel3", 4'b0010, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("fix_g2", 4'b0010, 4'b0010, 3'b010, 1'b1, 1'b0);
    cyc("fix_idle", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Hold limit: 4 cycles of owner 4, forced handover to 1, then back to 4
    for (int i = 0; i < 4; i++) cyc("hold_4", 4'b1001, 4'b1000, 3'b100, 1'b1, 1'b0);
    cyc("hold_exp1", 4'b1001, 4'b0001, 3'b001, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("hold_1", 4'b1001, 4'b0001, 3'b001, 1'b1, 1'b0);
    cyc("hold_exp4", 4'b1001, 4'b1000, 3'b100, 1'b1, 1'b1);
    cyc("hold_idle", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Sole requester keeps ownership; a late competitor sees the saturated count
    for (int i = 0; i < 20; i++) cyc("sole_3", 4'b0100, 4'b0100, 3'b011, 1'b1, 1'b0);
    cyc("sat_exp", 4'b0110, 4'b0010, 3'b010, 1'b1, 1'b1);
    cyc("sat_idle", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Round-robin from a fresh reset: 4, 3, 2, 1, 4
    rst_n = 1'b0;
    cyc("rr_rst", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    rr = 1'b1;
    cyc("rr_g4", 4'b1111, 4'b1000, 3'b100, 1'b1, 1'b0);
    cyc("rr_d4", 4'b0111, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("rr_g3", 4'b1111, 4'b0100, 3'b011, 1'b1, 1'b0);
    cyc("rr_d3", 4'b1011, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("rr_g2", 4'b1111, 4'b0010, 3'b010, 1'b1, 1'b0);
    cyc("rr_d2", 4'b1101, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("rr_g1", 4'b1111, 4'b0001, 3'b001, 1'b1, 1'b0);
    cyc("rr_d1", 4'b1110, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("rr_g4b", 4'b1111, 4'b1000, 3'b100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("rr_hold4", 4'b1111, 4'b1000, 3'b100, 1'b1, 1'b0);
    cyc("rr_exp3", 4'b1111, 4'b0100, 3'b011, 1'b1, 1'b1);
    cyc("rr_idle", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Reset mid-ownership drops the grant at that edge
    rr = 1'b0;
    cyc("mid_g2", 4'b0010, 4'b0010, 3'b010, 1'b1, 1'b0);
    rst_n = 1'b0;
    cyc("mid_rst", 4'b0010, 4'b0000, 3'b000, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("mid_regrant", 4'b0010, 4'b0010, 3'b010, 1'b1, 1'b0);
    cyc("mid_idle", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    // Release coinciding with expiry: idle cycle, no expire pulse
    for (int i = 0; i < 4; i++) cyc("col_4", 4'b1001, 4'b1000, 3'b100, 1'b1, 1'b0);
    cyc("col_rel", 4'b0001, 4'b0000, 3'b000, 1'b0, 1'b0);
    cyc("col_g1", 4'b0001, 4'b0001, 3'b001, 1'b1, 1'b0);
    cyc("col_idle", 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
